// File: rtl/ddr4_dfi_init_seq.sv
// DDR4 power-up / initialisation sequencer on the DFI phase-0 control fields.
// Drives DRAM reset, CKE, DFI init handshake, per-rank MRS programming and ZQCL.
module ddr4_dfi_init_seq #(
  parameter int CS_WIDTH     = 1,
  parameter int A_WIDTH      = 17,
  parameter int BA_WIDTH     = 2,
  parameter int BG_WIDTH     = 2,
  parameter int RST_CYC      = 16,
  parameter int CKE_CYC      = 32,
  parameter int TMOD_CYC     = 24,
  parameter int TZQINIT_CYC  = 512,
  parameter int INIT_TIMEOUT = 4096
) (
  input  logic                  dfi_clk,
  input  logic                  reset_n,
  input  logic                  reinit,
  input  logic [7*A_WIDTH-1:0]  mr_data,
  input  logic                  dfi_init_complete,
  output logic                  dfi_init_start,
  output logic [CS_WIDTH-1:0]   dfi_reset_n,
  output logic [CS_WIDTH-1:0]   dfi_cke,
  output logic [CS_WIDTH-1:0]   dfi_cs_n,
  output logic                  dfi_act_n,
  output logic                  dfi_ras_n,
  output logic                  dfi_cas_n,
  output logic                  dfi_we_n,
  output logic [A_WIDTH-1:0]    dfi_address,
  output logic [BA_WIDTH-1:0]   dfi_bank,
  output logic [BG_WIDTH-1:0]   dfi_bg,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_error
);

  localparam int RK_W = (CS_WIDTH > 1) ? $clog2(CS_WIDTH) : 1;
  localparam int MW   = $clog2(7 * A_WIDTH);

  localparam logic [RK_W-1:0] LAST_RANK = RK_W'(CS_WIDTH - 1);
  localparam logic [15:0] RST_INIT = 16'(RST_CYC);
  localparam logic [15:0] RST_LD   = 16'(RST_CYC - 1);
  localparam logic [15:0] CKE_LD   = 16'(CKE_CYC - 1);
  localparam logic [15:0] TMOD_LD  = 16'(TMOD_CYC - 1);
  localparam logic [15:0] TZQ_LD   = 16'(TZQINIT_CYC - 1);
  localparam logic [15:0] TO_LD    = 16'(INIT_TIMEOUT - 1);

  localparam logic [3:0] ST_RST_HOLD = 4'd0;
  localparam logic [3:0] ST_CKE_WAIT = 4'd1;
  localparam logic [3:0] ST_PHY_INIT = 4'd2;
  localparam logic [3:0] ST_MRS_CMD  = 4'd3;
  localparam logic [3:0] ST_MRS_GAP  = 4'd4;
  localparam logic [3:0] ST_ZQ_CMD   = 4'd5;
  localparam logic [3:0] ST_ZQ_GAP   = 4'd6;
  localparam logic [3:0] ST_FINISH   = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;
  localparam logic [3:0] ST_ERROR    = 4'd9;

  logic [3:0]          state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [RK_W-1:0]     rank_q, rank_d;
  logic [2:0]          mr_q, mr_d;
  logic [CS_WIDTH-1:0] rstn_q, rstn_d;
  logic [CS_WIDTH-1:0] cke_q, cke_d;
  logic [CS_WIDTH-1:0] cs_q, cs_d;
  logic                start_q, start_d;
  logic                act_q, act_d, ras_q, ras_d, cas_q, cas_d, we_q, we_d;
  logic [A_WIDTH-1:0]  addr_q, addr_d;
  logic [BA_WIDTH-1:0] bank_q, bank_d;
  logic [BG_WIDTH-1:0] bg_q, bg_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [2:0]    mr_num;
  logic [MW-1:0] mr_lsb;
  logic          mr_last, rank_last;
  logic [3:0]    mrs_next;
  logic [2:0]    mr_next;
  logic [RK_W-1:0] rank_mrs_next;

  // JEDEC programming order MR3, MR6, MR5, MR4, MR2, MR1, MR0
  always_comb begin
    case (mr_q)
      3'd0:    mr_num = 3'd3;
      3'd1:    mr_num = 3'd6;
      3'd2:    mr_num = 3'd5;
      3'd3:    mr_num = 3'd4;
      3'd4:    mr_num = 3'd2;
      3'd5:    mr_num = 3'd1;
      default: mr_num = 3'd0;
    endcase
    mr_lsb = MW'(mr_num * A_WIDTH);
  end

  always_comb begin
    mr_last       = (mr_q == 3'd6);
    rank_last     = (rank_q == LAST_RANK);
    mrs_next      = (mr_last && rank_last) ? ST_ZQ_CMD : ST_MRS_CMD;
    mr_next       = mr_last ? 3'd0 : mr_q + 3'd1;
    rank_mrs_next = mr_last ? (rank_last ? '0 : rank_q + 1'b1) : rank_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rank_d  = rank_q;
    mr_d    = mr_q;
    rstn_d  = rstn_q;
    cke_d   = cke_q;
    start_d = start_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    cs_d    = '1;
    act_d   = 1'b1;
    ras_d   = 1'b1;
    cas_d   = 1'b1;
    we_d    = 1'b1;
    addr_d  = '0;
    bank_d  = '0;
    bg_d    = '0;

    case (state_q)
      ST_RST_HOLD: begin
        if (cnt_q == 16'd0) begin
          rstn_d  = '1;
          cnt_d   = CKE_LD;
          state_d = ST_CKE_WAIT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_CKE_WAIT: begin
        if (cnt_q == 16'd0) begin
          cke_d   = '1;
          start_d = 1'b1;
          cnt_d   = TO_LD;
          // Completion already high on the rising edge of init_start is accepted
          state_d = dfi_init_complete ? ST_MRS_CMD : ST_PHY_INIT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_PHY_INIT: begin
        if (dfi_init_complete) begin
          state_d = ST_MRS_CMD;
        end else if (INIT_TIMEOUT > 0 && cnt_q == 16'd0) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_ERROR;
        end else if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_MRS_CMD: begin
        start_d      = 1'b0;
        cs_d[rank_q] = 1'b0;
        ras_d        = 1'b0;
        cas_d        = 1'b0;
        we_d         = 1'b0;
        addr_d       = mr_data[mr_lsb +: A_WIDTH];
        bank_d[1:0]  = mr_num[1:0];
        bg_d[0]      = mr_num[2];
        if (TMOD_CYC == 0) begin
          state_d = mrs_next;
          mr_d    = mr_next;
          rank_d  = rank_mrs_next;
        end else begin
          cnt_d   = TMOD_LD;
          state_d = ST_MRS_GAP;
        end
      end
      ST_MRS_GAP: begin
        if (cnt_q == 16'd0) begin
          state_d = mrs_next;
          mr_d    = mr_next;
          rank_d  = rank_mrs_next;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_ZQ_CMD: begin
        cs_d[rank_q] = 1'b0;
        we_d         = 1'b0;
        addr_d[10]   = 1'b1;
        if (TZQINIT_CYC == 0) begin
          state_d = rank_last ? ST_FINISH : ST_ZQ_CMD;
          rank_d  = rank_last ? '0 : rank_q + 1'b1;
        end else begin
          cnt_d   = TZQ_LD;
          state_d = ST_ZQ_GAP;
        end
      end
      ST_ZQ_GAP: begin
        if (cnt_q == 16'd0) begin
          state_d = rank_last ? ST_FINISH : ST_ZQ_CMD;
          rank_d  = rank_last ? '0 : rank_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE, ST_ERROR: begin
        // Restart edge acts as edge 0 of the new sequence
        if (reinit) begin
          state_d = ST_RST_HOLD;
          cnt_d   = RST_LD;
          rank_d  = '0;
          mr_d    = 3'd0;
          rstn_d  = '0;
          cke_d   = '0;
          start_d = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_RST_HOLD;
    endcase
  end

  always_ff @(posedge dfi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RST_HOLD;
      cnt_q   <= RST_INIT;
      rank_q  <= '0;
      mr_q    <= 3'd0;
      rstn_q  <= '0;
      cke_q   <= '0;
      cs_q    <= '1;
      start_q <= 1'b0;
      act_q   <= 1'b1;
      ras_q   <= 1'b1;
      cas_q   <= 1'b1;
      we_q    <= 1'b1;
      addr_q  <= '0;
      bank_q  <= '0;
      bg_q    <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rank_q  <= rank_d;
      mr_q    <= mr_d;
      rstn_q  <= rstn_d;
      cke_q   <= cke_d;
      cs_q    <= cs_d;
      start_q <= start_d;
      act_q   <= act_d;
      ras_q   <= ras_d;
      cas_q   <= cas_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      bg_q    <= bg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dfi_init_start = start_q;
  assign dfi_reset_n    = rstn_q;
  assign dfi_cke        = cke_q;
  assign dfi_cs_n       = cs_q;
  assign dfi_act_n      = act_q;
  assign dfi_ras_n      = ras_q;
  assign dfi_cas_n      = cas_q;
  assign dfi_we_n       = we_q;
  assign dfi_address    = addr_q;
  assign dfi_bank       = bank_q;
  assign dfi_bg         = bg_q;
  assign busy           = busy_q;
  assign init_done      = done_q;
  assign init_error     = err_q;

endmodule

// File: tb/tb_ddr4_dfi_init_seq.sv
// Bench for ddr4_dfi_init_seq: per-edge comparison against an arithmetic schedule model.
module tb_ddr4_dfi_init_seq;

  typedef struct packed {
    logic [1:0]  rstn;
    logic [1:0]  cke;
    logic        start;
    logic [1:0]  cs;
    logic        act, ras, cas, we;
    logic [16:0] addr;
    logic [1:0]  bank;
    logic [1:0]  bg;
    logic        busy, done, err;
  } obs_t;

  typedef struct {
    int rst, cke, tmod, tzq, cs, to;
  } cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;

  logic         rst_a, rst_b, reinit, complete;
  logic [118:0] mr_data;

  logic [1:0]  rstn_a, cke_a, cs_a, bank_a, bg_a;
  logic        start_a, act_a, ras_a, cas_a, we_a, busy_a, done_a, err_a;
  logic [16:0] addr_a;
  logic        rstn_b, cke_b, cs_b;
  logic [1:0]  bank_b, bg_b;
  logic        start_b, act_b, ras_b, cas_b, we_b, busy_b, done_b, err_b;
  logic [16:0] addr_b;

  ddr4_dfi_init_seq #(
    .CS_WIDTH(2), .A_WIDTH(17), .BA_WIDTH(2), .BG_WIDTH(2), .RST_CYC(4),
    .CKE_CYC(8), .TMOD_CYC(2), .TZQINIT_CYC(16), .INIT_TIMEOUT(64)
  ) u_dut_a (
    .dfi_clk(clk), .reset_n(rst_a), .reinit(reinit), .mr_data(mr_data),
    .dfi_init_complete(complete), .dfi_init_start(start_a), .dfi_reset_n(rstn_a),
    .dfi_cke(cke_a), .dfi_cs_n(cs_a), .dfi_act_n(act_a), .dfi_ras_n(ras_a),
    .dfi_cas_n(cas_a), .dfi_we_n(we_a), .dfi_address(addr_a), .dfi_bank(bank_a),
    .dfi_bg(bg_a), .busy(busy_a), .init_done(done_a), .init_error(err_a)
  );

  ddr4_dfi_init_seq #(
    .CS_WIDTH(1), .A_WIDTH(17), .BA_WIDTH(2), .BG_WIDTH(2), .RST_CYC(3),
    .CKE_CYC(5), .TMOD_CYC(0), .TZQINIT_CYC(0), .INIT_TIMEOUT(0)
  ) u_dut_b (
    .dfi_clk(clk), .reset_n(rst_b), .reinit(reinit), .mr_data(mr_data),
    .dfi_init_complete(complete), .dfi_init_start(start_b), .dfi_reset_n(rstn_b),
    .dfi_cke(cke_b), .dfi_cs_n(cs_b), .dfi_act_n(act_b), .dfi_ras_n(ras_b),
    .dfi_cas_n(cas_b), .dfi_we_n(we_b), .dfi_address(addr_b), .dfi_bank(bank_b),
    .dfi_bg(bg_b), .busy(busy_b), .init_done(done_b), .init_error(err_b)
  );

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.cs = 2'b11;
    o.act = 1'b1; o.ras = 1'b1; o.cas = 1'b1; o.we = 1'b1;
    o.busy = 1'b1;
    return o;
  endfunction

  // Expected outputs after edge e, from the published schedule arithmetic
  function automatic obs_t model(input int e, input int n, input bit acc,
                                 input cfg_t c, input logic [118:0] md);
    obs_t o;
    int ord[7];
    int s, p, z0, q, off, k, mr;
    ord = '{3, 6, 5, 4, 2, 1, 0};
    o = idle_obs();
    s = c.rst + c.cke;
    if (e >= c.rst) o.rstn = 2'b11;
    if (e >= s) begin o.cke = 2'b11; o.start = 1'b1; end
    if (!acc) begin
      if (c.to > 0 && e >= s + c.to) begin
        o.start = 1'b0; o.err = 1'b1; o.busy = 1'b0;
      end
      return o;
    end
    if (e > n) o.start = 1'b0;
    p  = c.tmod + 1;
    q  = c.tzq + 1;
    z0 = n + 1 + c.cs * 7 * p;
    if (e > n && e < z0) begin
      off = e - n - 1;
      k = off % (7 * p);
      if (k % p == 0) begin
        mr = ord[k / p];
        o.cs = ~(2'(1) << (off / (7 * p)));
        o.ras = 1'b0; o.cas = 1'b0; o.we = 1'b0;
        o.addr = md[mr*17 +: 17];
        o.bank = 2'(mr);
        o.bg = {1'b0, 1'(mr >> 2)};
      end
    end else if (e >= z0 && e < z0 + c.cs * q) begin
      off = e - z0;
      if (off % q == 0) begin
        o.cs = ~(2'(1) << (off / q));
        o.we = 1'b0;
        o.addr = 17'h00400;
      end
    end else if (e >= z0 + c.cs * q) begin
      o.done = 1'b1; o.busy = 1'b0;
    end
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    if (sel == 0) begin
      o.rstn = rstn_a; o.cke = cke_a; o.cs = cs_a; o.start = start_a;
      o.act = act_a; o.ras = ras_a; o.cas = cas_a; o.we = we_a;
      o.addr = addr_a; o.bank = bank_a; o.bg = bg_a;
      o.busy = busy_a; o.done = done_a; o.err = err_a;
    end else begin
      o.rstn = {2{rstn_b}}; o.cke = {2{cke_b}}; o.cs = {1'b1, cs_b}; o.start = start_b;
      o.act = act_b; o.ras = ras_b; o.cas = cas_b; o.we = we_b;
      o.addr = addr_b; o.bank = bank_b; o.bg = bg_b;
      o.busy = busy_b; o.done = done_b; o.err = err_b;
    end
    return o;
  endfunction

  function automatic logic [118:0] rand_md();
    logic [118:0] r;
    for (int i = 0; i < 7; i++) r[i*17 +: 17] = 17'($urandom);
    return r;
  endfunction

  task automatic check(input string tag, input int e, input obs_t exp);
    obs_t got;
    got = sample();
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s edge %0d: observed %h expected %h", tag, e, got, exp);
    end
  endtask

  // Starts a sequence (reset release or reinit) at the next edge, checks every edge
  task automatic run_seq(input string tag, input cfg_t c, input int n, input bit acc,
                         input bit via_reinit, input bit glitch, input int stop,
                         input logic [118:0] md);
    int s, dn, last;
    s    = c.rst + c.cke;
    dn   = n + 1 + c.cs * 7 * (c.tmod + 1) + c.cs * (c.tzq + 1);
    last = acc ? dn + 3 : s + c.to + 3;
    if (stop >= 0) last = stop;
    mr_data = md;
    if (!via_reinit) begin
      if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
    end
    for (int e = 0; e <= last; e++) begin
      if (e == 0) reinit = via_reinit;
      else reinit = glitch && (acc ? e < dn : e < s + c.to) && ($urandom_range(4) == 0);
      complete = acc && e >= n && (e == n || $urandom_range(1) == 1);
      @(posedge clk);
      @(negedge clk);
      check(tag, e, model(e, n, acc, c, md));
    end
    reinit = 1'b0;
    complete = 1'b0;
  endtask

  initial begin
    cfg_t ca, cb;
    logic [118:0] md;
    ca = '{4, 8, 2, 16, 2, 64};
    cb = '{3, 5, 0, 0, 1, 0};
    rst_a = 1'b0; rst_b = 1'b0; reinit = 1'b0; complete = 1'b0; mr_data = '0;
    for (int i = 0; i < 7; i++) md[i*17 +: 17] = 17'h01000 + 17'(i);

    repeat (3) @(negedge clk);
    sel = 0; check("reset_a", -1, idle_obs());
    sel = 1; check("reset_b", -1, idle_obs());
    sel = 0;

    run_seq("plan", ca, 20, 1'b1, 1'b0, 1'b0, -1, md);
    run_seq("cmp_at_start", ca, 12, 1'b1, 1'b1, 1'b1, -1, rand_md());
    run_seq("cmp_at_timeout", ca, 76, 1'b1, 1'b1, 1'b1, -1, rand_md());
    run_seq("timeout", ca, 0, 1'b0, 1'b1, 1'b1, -1, rand_md());
    run_seq("after_error", ca, 20, 1'b1, 1'b1, 1'b0, -1, md);
    for (int i = 0; i < 3; i++)
      run_seq("rand_a", ca, int'($urandom_range(76, 12)), 1'b1, 1'b1, 1'b1, -1, rand_md());

    run_seq("abort", ca, 20, 1'b1, 1'b1, 1'b0, 30, md);
    #1 rst_a = 1'b0;
    #1 check("async_reset", 30, idle_obs());
    run_seq("post_reset", ca, int'($urandom_range(76, 12)), 1'b1, 1'b0, 1'b1, -1, rand_md());

    rst_a = 1'b0;
    sel = 1;
    run_seq("b_back2back", cb, 8, 1'b1, 1'b0, 1'b0, -1, md);
    for (int i = 0; i < 3; i++)
      run_seq("rand_b", cb, int'($urandom_range(200, 8)), 1'b1, 1'b1, 1'b1, -1, rand_md());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
